// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: accepts one decoded instruction, decides perform from
// the N/Z/P flags and condition mask, and steps ALU, memory and writeback enables.
module exec_sequencer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        InstValid,
  output logic        InstReady,
  input  logic [3:0]  Op,
  input  logic [2:0]  CC,
  input  logic [15:0] ALUOut,
  input  logic        MemAck,
  output logic        ALUEn,
  output logic        MemReq,
  output logic        MemWe,
  output logic        RegWe,
  output logic        PCLoad,
  output logic        Perform,
  output logic [2:0]  Flags,
  output logic        Halted
);

  // state | meaning
  // IDLE  | ready for the next instruction
  // EXEC  | single ALU cycle; perform decided, flags updated on exit
  // MEM   | data memory access outstanding until MemAck
  // WB    | register-file write for one cycle
  // HALT  | stopped; only reset leaves
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  cc_q, cc_d;
  logic [2:0]  flags_q, flags_d;
  logic        perform_q, perform_d;

  logic        is_cond_alu, is_uncond_alu, is_lui, is_cpi;
  logic        is_load, is_store, is_branch, is_jump, is_halt;
  logic        match, exec_perform;
  logic [2:0]  alu_nzp;

  always_comb begin
    is_cond_alu   = 1'b0;
    is_uncond_alu = 1'b0;
    is_lui        = 1'b0;
    is_cpi        = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    is_branch     = 1'b0;
    is_jump       = 1'b0;
    is_halt       = 1'b0;
    case (op_q)
      4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110: is_cond_alu = 1'b1;
      4'b0001, 4'b1101: is_uncond_alu = 1'b1;
      4'b0011: is_lui    = 1'b1;
      4'b0111: is_cpi    = 1'b1;
      4'b1000: is_load   = 1'b1;
      4'b1001: is_store  = 1'b1;
      4'b1010: is_branch = 1'b1;
      4'b1011: is_jump   = 1'b1;
      4'b1111: is_halt   = 1'b1;
      default: ;
    endcase
  end

  assign match = (|(cc_q & flags_q)) | (cc_q == 3'b111);

  // cpi, nop and halt never perform; unconditional classes always do
  assign exec_perform = ((is_cond_alu | is_load | is_store | is_branch) & match)
                      | is_uncond_alu | is_lui | is_jump;

  assign alu_nzp = ALUOut[15] ? 3'b100 : ((ALUOut == 16'h0000) ? 3'b010 : 3'b001);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cc_d      = cc_q;
    flags_d   = flags_q;
    perform_d = perform_q;
    InstReady = 1'b0;
    ALUEn     = 1'b0;
    MemReq    = 1'b0;
    MemWe     = 1'b0;
    RegWe     = 1'b0;
    PCLoad    = 1'b0;
    Halted    = 1'b0;
    case (state_q)
      S_IDLE: begin
        InstReady = 1'b1;
        if (InstValid) begin
          op_d    = Op;
          cc_d    = CC;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUEn     = 1'b1;
        perform_d = exec_perform;
        PCLoad    = (is_branch | is_jump) & exec_perform;
        if (is_cpi | ((is_cond_alu | is_uncond_alu) & exec_perform))
          flags_d = alu_nzp;
        if (is_halt)
          state_d = S_HALT;
        else if ((is_load | is_store) & exec_perform)
          state_d = S_MEM;
        else if ((is_cond_alu | is_uncond_alu | is_lui) & exec_perform)
          state_d = S_WB;
        else
          state_d = S_IDLE;
      end
      S_MEM: begin
        MemReq = 1'b1;
        MemWe  = is_store;
        if (MemAck)
          state_d = is_load ? S_WB : S_IDLE;
      end
      S_WB: begin
        RegWe   = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      op_q      <= 4'b1100;
      cc_q      <= 3'b000;
      flags_q   <= 3'b010;
      perform_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cc_q      <= cc_d;
      flags_q   <= flags_d;
      perform_q <= perform_d;
    end
  end

  assign Flags   = flags_q;
  assign Perform = perform_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed scenarios plus randomized instructions checked
// against an instruction-level reference model.
module tb_exec_sequencer;

  logic        CLK;
  logic        Reset;
  logic        InstValid;
  logic        InstReady;
  logic [3:0]  Op;
  logic [2:0]  CC;
  logic [15:0] ALUOut;
  logic        MemAck;
  logic        ALUEn, MemReq, MemWe, RegWe, PCLoad, Perform, Halted;
  logic [2:0]  Flags;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] m_flags;

  typedef struct {
    int lat;
    int aluen;
    int regwe;
    int memreq;
    int memwe;
    int pcload;
    int halted;
    bit perform;
    logic [2:0] flags;
  } obs_t;

  exec_sequencer dut (
    .CLK(CLK), .Reset(Reset), .InstValid(InstValid), .InstReady(InstReady),
    .Op(Op), .CC(CC), .ALUOut(ALUOut), .MemAck(MemAck),
    .ALUEn(ALUEn), .MemReq(MemReq), .MemWe(MemWe), .RegWe(RegWe),
    .PCLoad(PCLoad), .Perform(Perform), .Flags(Flags), .Halted(Halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Instruction-level model: what one instruction should do, given the flags before it.
  function automatic obs_t ref_model(input logic [3:0] op, input logic [2:0] cc,
                                     input logic [2:0] flags, input logic [15:0] alu,
                                     input int nack);
    obs_t e;
    bit cond_alu, u_alu, lui, cpi, ld, st, br, jmp, hlt, m, p;
    cond_alu = (op == 0) || (op == 2) || (op == 4) || (op == 5) || (op == 6);
    u_alu = (op == 1) || (op == 13);
    lui = (op == 3); cpi = (op == 7); ld = (op == 8); st = (op == 9);
    br = (op == 10); jmp = (op == 11); hlt = (op == 15);
    m = ((cc & flags) != 0) || (cc == 3'b111);
    if (cond_alu || ld || st || br) p = m;
    else p = u_alu || lui || jmp;
    e.perform = p;
    e.flags = flags;
    if (cpi || ((cond_alu || u_alu) && p))
      e.flags = alu[15] ? 3'b100 : (alu == 0 ? 3'b010 : 3'b001);
    e.aluen  = 1;
    e.regwe  = ((cond_alu || u_alu || lui || ld) && p) ? 1 : 0;
    e.memreq = ((ld || st) && p) ? nack : 0;
    e.memwe  = (st && p) ? nack : 0;
    e.pcload = ((br || jmp) && p) ? 1 : 0;
    e.halted = hlt ? 1 : 0;
    if (hlt) e.lat = 2;
    else if (ld && p) e.lat = 3 + nack;
    else if (st && p) e.lat = 2 + nack;
    else if ((cond_alu || u_alu || lui) && p) e.lat = 3;
    else e.lat = 2;
    return e;
  endfunction

  // Issue one instruction from IDLE and tally output activity until ready or halted.
  task automatic run_inst(input logic [3:0] op, input logic [2:0] cc, input logic [15:0] alu,
                          input int nack, input bit noise, output obs_t o);
    int memcnt;
    o = '{default: 0};
    memcnt = 0;
    @(negedge CLK);
    InstValid = 1'b1; Op = op; CC = cc; ALUOut = alu; MemAck = 1'b0;
    @(posedge CLK);
    #1;
    InstValid = 1'b0;
    Op = 4'($urandom);
    CC = 3'($urandom);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      o.lat++;
      if (ALUEn)  o.aluen++;
      if (RegWe)  o.regwe++;
      if (MemWe)  o.memwe++;
      if (PCLoad) o.pcload++;
      if (Halted) o.halted++;
      if (MemReq) begin
        o.memreq++;
        memcnt++;
        MemAck = (memcnt == nack);
      end else begin
        MemAck = noise ? 1'($urandom) : 1'b0;
      end
      if (InstReady || Halted) break;
    end
    MemAck = 1'b0;
    o.perform = Perform;
    o.flags = Flags;
  endtask

  task automatic test_reset();
    Reset = 1'b0; InstValid = 1'b0; Op = 4'h0; CC = 3'h0; ALUOut = 16'h0; MemAck = 1'b0;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    n_tests++;
    if ({InstReady, ALUEn, MemReq, MemWe, RegWe, PCLoad, Perform, Halted} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 10000000",
               {InstReady, ALUEn, MemReq, MemWe, RegWe, PCLoad, Perform, Halted});
    end
    n_tests++;
    if (Flags !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 010", Flags);
    end
    m_flags = 3'b010;
  endtask

  task automatic test_addi();
    obs_t o;
    run_inst(4'b0001, 3'b000, 16'h8000, 1, 1'b0, o);
    n_tests++;
    if (o.perform !== 1'b1 || o.regwe != 1 || o.flags !== 3'b100 || o.lat != 3 || o.aluen != 1) begin
      n_fail++;
      $display("FAIL addi: perform=%b regwe=%0d flags=%b lat=%0d aluen=%0d expected 1 1 100 3 1",
               o.perform, o.regwe, o.flags, o.lat, o.aluen);
    end
    m_flags = 3'b100;
  endtask

  task automatic test_cond_alu();
    obs_t o;
    run_inst(4'b0111, 3'b000, 16'h0000, 1, 1'b0, o);
    run_inst(4'b0000, 3'b001, 16'h1234, 1, 1'b0, o);
    n_tests++;
    if (o.perform !== 1'b0 || o.regwe != 0 || o.memreq != 0 || o.flags !== 3'b010 || o.lat != 2) begin
      n_fail++;
      $display("FAIL cond_suppressed: perform=%b regwe=%0d memreq=%0d flags=%b lat=%0d expected 0 0 0 010 2",
               o.perform, o.regwe, o.memreq, o.flags, o.lat);
    end
    run_inst(4'b0000, 3'b010, 16'h0005, 1, 1'b0, o);
    n_tests++;
    if (o.perform !== 1'b1 || o.regwe != 1 || o.flags !== 3'b001 || o.lat != 3) begin
      n_fail++;
      $display("FAIL cond_taken: perform=%b regwe=%0d flags=%b lat=%0d expected 1 1 001 3",
               o.perform, o.regwe, o.flags, o.lat);
    end
    m_flags = 3'b001;
  endtask

  task automatic test_cpi_branch();
    obs_t o;
    run_inst(4'b0111, 3'b111, 16'h0000, 1, 1'b0, o);
    n_tests++;
    if (o.perform !== 1'b0 || o.regwe != 0 || o.flags !== 3'b010 || o.lat != 2) begin
      n_fail++;
      $display("FAIL cpi: perform=%b regwe=%0d flags=%b lat=%0d expected 0 0 010 2",
               o.perform, o.regwe, o.flags, o.lat);
    end
    run_inst(4'b1010, 3'b010, 16'hFFFF, 1, 1'b0, o);
    n_tests++;
    if (o.pcload != 1 || o.perform !== 1'b1 || o.regwe != 0 || o.flags !== 3'b010 || o.lat != 2) begin
      n_fail++;
      $display("FAIL branch: pcload=%0d perform=%b regwe=%0d flags=%b lat=%0d expected 1 1 0 010 2",
               o.pcload, o.perform, o.regwe, o.flags, o.lat);
    end
    m_flags = 3'b010;
  endtask

  task automatic test_load_store();
    obs_t o;
    run_inst(4'b1000, 3'b111, 16'h8001, 5, 1'b1, o);
    n_tests++;
    if (o.memreq != 5 || o.memwe != 0 || o.regwe != 1 || o.lat != 8 || o.flags !== 3'b010) begin
      n_fail++;
      $display("FAIL load: memreq=%0d memwe=%0d regwe=%0d lat=%0d flags=%b expected 5 0 1 8 010",
               o.memreq, o.memwe, o.regwe, o.lat, o.flags);
    end
    run_inst(4'b1001, 3'b010, 16'h0001, 5, 1'b1, o);
    n_tests++;
    if (o.memreq != 5 || o.memwe != 5 || o.regwe != 0 || o.lat != 7) begin
      n_fail++;
      $display("FAIL store: memreq=%0d memwe=%0d regwe=%0d lat=%0d expected 5 5 0 7",
               o.memreq, o.memwe, o.regwe, o.lat);
    end
  endtask

  task automatic test_reset_in_mem();
    @(negedge CLK);
    InstValid = 1'b1; Op = 4'b1000; CC = 3'b111; ALUOut = 16'h0000;
    @(posedge CLK);
    #1 InstValid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    MemAck = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (MemReq !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_reset_pre: memreq=%b expected 1", MemReq);
    end
    Reset = 1'b0;
    MemAck = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (InstReady !== 1'b1 || MemReq !== 1'b0 || RegWe !== 1'b0 || Flags !== 3'b010) begin
      n_fail++;
      $display("FAIL mem_reset: ready=%b memreq=%b regwe=%b flags=%b expected 1 0 0 010",
               InstReady, MemReq, RegWe, Flags);
    end
    Reset = 1'b1;
    MemAck = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (InstReady !== 1'b1 || RegWe !== 1'b0 || MemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_reset_after: ready=%b regwe=%b memreq=%b expected 1 0 0",
               InstReady, RegWe, MemReq);
    end
    m_flags = 3'b010;
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [3:0] op;
    logic [2:0] cc;
    logic [15:0] alu;
    int nack;
    for (int k = 0; k < 80; k++) begin
      op = 4'($urandom_range(0, 14));
      cc = 3'($urandom);
      case ($urandom_range(0, 3))
        0: alu = 16'h0000;
        1: alu = 16'h8000 | 16'($urandom);
        default: alu = 16'($urandom);
      endcase
      nack = $urandom_range(1, 4);
      e = ref_model(op, cc, m_flags, alu, nack);
      run_inst(op, cc, alu, nack, 1'b1, o);
      n_tests++;
      if (o.lat != e.lat || o.aluen != e.aluen || o.regwe != e.regwe || o.memreq != e.memreq ||
          o.memwe != e.memwe || o.pcload != e.pcload || o.halted != e.halted ||
          o.perform !== e.perform || o.flags !== e.flags) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%h cc=%b alu=%h: got lat=%0d alu=%0d rwe=%0d mreq=%0d mwe=%0d pcl=%0d p=%b f=%b expected lat=%0d alu=%0d rwe=%0d mreq=%0d mwe=%0d pcl=%0d p=%b f=%b",
                 k, op, cc, alu, o.lat, o.aluen, o.regwe, o.memreq, o.memwe, o.pcload,
                 o.perform, o.flags, e.lat, e.aluen, e.regwe, e.memreq, e.memwe, e.pcload,
                 e.perform, e.flags);
      end
      m_flags = e.flags;
    end
  endtask

  task automatic test_halt();
    obs_t o;
    int bad;
    run_inst(4'b1111, 3'b111, 16'h8000, 1, 1'b0, o);
    n_tests++;
    if (o.halted != 1 || o.lat != 2 || o.perform !== 1'b0 || o.regwe != 0 || o.flags !== m_flags) begin
      n_fail++;
      $display("FAIL halt_enter: halted=%0d lat=%0d perform=%b regwe=%0d flags=%b expected 1 2 0 0 %b",
               o.halted, o.lat, o.perform, o.regwe, o.flags, m_flags);
    end
    InstValid = 1'b1; Op = 4'b0001; CC = 3'b111;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      MemAck = 1'($urandom);
      if (InstReady !== 1'b0 || Halted !== 1'b1 || ALUEn || MemReq || RegWe || PCLoad) bad++;
    end
    MemAck = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_hold: %0d bad cycles, expected 0", bad);
    end
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    InstValid = 1'b0;
    n_tests++;
    if (InstReady !== 1'b1 || Halted !== 1'b0 || Flags !== 3'b010 || Perform !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: ready=%b halted=%b flags=%b perform=%b expected 1 0 010 0",
               InstReady, Halted, Flags, Perform);
    end
    m_flags = 3'b010;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_cond_alu();
    test_cpi_branch();
    test_load_store();
    test_reset_in_mem();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
